router_ingress: RTL and testbench
=================================

Name: router_ingress

Overview:
Input stage of the 1x3 router. It consumes the byte stream driven on clock/resetn/pkt_valid/data_in and returns busy/error to the source. It frames each packet (header, payload, parity), computes and checks parity, and steers every byte into one of NUM_DEST destination FIFOs through a one-entry output slot. It stalls the source with busy when the selected FIFO is full.

Parameters:
DATA_W, 8, byte width (header layout requires 8)
NUM_DEST, 3, destination FIFO count; header address >= NUM_DEST is invalid

Ports:
clock  input  1  single clock, all state on posedge
resetn  input  1  synchronous, active-low reset
pkt_valid  input  1  source byte valid
data_in  input  DATA_W  source byte
fifo_full  input  NUM_DEST  per-destination FIFO full
busy  output  1  source must not present a new byte; a byte is accepted only when pkt_valid=1 and busy=0 at posedge
error  output  1  packet error flag (parity mismatch or invalid address)
write_enb  output  NUM_DEST  one-hot FIFO write strobe
dout  output  DATA_W  FIFO write data

Behaviour:
- Packet format:
  - header: [1:0]=dest, [7:2]=len (0..63 payload bytes)
  - then len payload bytes
  - then 1 parity byte = XOR of header and all payload bytes
  - pkt_valid may drop between bytes; this is a gap, not an abort.
- Reset (resetn=0 at posedge): state IDLE, slot empty, counters and parity accumulator cleared, error=0. Outputs after reset: busy=0, write_enb=0, dout=0. Reset mid-packet discards the packet and the slot contents.
- Output slot (dout, slot_valid, dest):
  - write_enb[dest] = slot_valid & ~fifo_full[dest]. This is combinational; the FIFO captures it at posedge.
  - The slot drains on a write. It may drain and refill on the same edge.
  - Latency: an accepted byte appears on dout the next cycle.
- busy (combinational from state and fifo_full): busy = (slot_valid & fifo_full[dest]) | (state==CHECK).
- States:
  - IDLE: on accept:
    - If data_in[1:0] < NUM_DEST: latch dest and len, set parity_acc=data_in, load slot, clear error. Go to PAYLOAD if len>0, else PARITY.
    - Otherwise (invalid): do not load slot, set drop_cnt=len+1, go to DROP.
  - PAYLOAD: each accept loads slot, parity_acc ^= data_in, rem_cnt--. When rem_cnt reaches 0, go to PARITY.
  - PARITY: on accept, load slot (parity byte is written to the FIFO), latch mismatch = (data_in != parity_acc), go to CHECK.
  - CHECK: exactly one cycle with busy=1. error <= mismatch. Go to IDLE.
  - DROP: accept bytes with no writes, decrementing drop_cnt. When it reaches 0, set error=1 and go to IDLE. busy=0 throughout DROP unless the slot is still stalled from a previous packet.
- error: registered. Holds until the next valid header is accepted or reset.
- Back-to-back packets: a header is accepted in the cycle after CHECK.
- A header for a new dest while the slot still holds the previous packet's parity byte for a full FIFO is blocked by busy, so ordering is preserved.
- A full FIFO with an empty slot does not assert busy.

Decomposition:
- router_pkg holds:
  - state enum (IDLE, PAYLOAD, PARITY, CHECK, DROP)
  - header field constants (ADDR_LSB=0, ADDR_W=2, LEN_LSB=2, LEN_W=6)
  - NUM_DEST default
- One natural sub-module: router_ingress_fsm, holding state, counters, parity and error. The top holds the output slot and the write_enb/busy logic.

Test Plan:
- Reset, then header 0x0D and payload 0x11,0x22,0x33, parity 0x0D, all FIFOs empty -> write_enb=3'b010 on 5 consecutive cycles starting 1 cycle after the header; dout = 0D,11,22,33,0D; busy=1 for one cycle after parity; error=0.
- Same packet with parity 0xFF -> all 5 bytes written; error=1 one cycle after CHECK; error clears when the next valid header is accepted.
- Header 0x08 (addr 0, len 2) with fifo_full[0]=1 for 4 cycles from the first write -> busy=1 while full with the slot occupied, no byte lost or duplicated; written sequence unchanged once full drops.
- Header 0x07 (addr 3, len 1) then 2 further bytes -> no write_enb; error=1 after the 3rd byte; busy=0 throughout.
- Header 0x02 (addr 2, len 0) then parity 0x02 -> exactly 2 writes to FIFO 2 with no payload; error=0.
- resetn=0 after the 2nd payload byte of a 3-byte packet -> next cycle write_enb=0, busy=0, error=0; a fresh header is then accepted normally.

Source files
------------

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the router ingress stage.
//   stateT             : ingress framing states
//   ADDR_LSB / ADDR_W  : position and width of the destination field in a header
//   LEN_LSB / LEN_W    : position and width of the payload length field
//   DATA_W_DEFAULT     : byte width (the header layout only works for 8)
//   NUM_DEST_DEFAULT   : number of destination FIFOs
// -----------------------------------------------------------------------------
package router_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PAYLOAD = 3'd1,
      PARITY  = 3'd2,
      CHECK   = 3'd3,
      DROP    = 3'd4
   } stateT;

   localparam int ADDR_LSB         = 0;
   localparam int ADDR_W           = 2;
   localparam int LEN_LSB          = 2;
   localparam int LEN_W            = 6;
   localparam int DATA_W_DEFAULT   = 8;
   localparam int NUM_DEST_DEFAULT = 3;

   // Destination field of a header byte.
   function automatic logic [ADDR_W-1:0] headerAddr(input logic [7:0] hdr);
      return hdr[ADDR_LSB +: ADDR_W];
   endfunction

   // Payload length field of a header byte.
   function automatic logic [LEN_W-1:0] headerLen(input logic [7:0] hdr);
      return hdr[LEN_LSB +: LEN_W];
   endfunction

endpackage

// File: rtl/router_ingress_if.sv
// -----------------------------------------------------------------------------
// router_ingress_if
// Bundles the byte-stream handshake from the source and the FIFO-side write bus.
//   pkt_valid  : source byte valid
//   data_in    : source byte
//   busy       : source must hold its byte this cycle
//   error      : packet error flag
//   fifo_full  : per-destination FIFO full
//   write_enb  : one-hot FIFO write strobe
//   dout       : FIFO write data
// Modports:
//   master : the environment (source and FIFOs) side
//   slave  : the router ingress side
// -----------------------------------------------------------------------------
interface router_ingress_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_DEST = 3
);

   logic                pkt_valid;
   logic [DATA_W-1:0]   data_in;
   logic                busy;
   logic                error;
   logic [NUM_DEST-1:0] fifo_full;
   logic [NUM_DEST-1:0] write_enb;
   logic [DATA_W-1:0]   dout;

   modport master (
      output pkt_valid,
      output data_in,
      output fifo_full,
      input  busy,
      input  error,
      input  write_enb,
      input  dout
   );

   modport slave (
      input  pkt_valid,
      input  data_in,
      input  fifo_full,
      output busy,
      output error,
      output write_enb,
      output dout
   );

endinterface

// File: rtl/router_ingress_fsm.sv
// -----------------------------------------------------------------------------
// router_ingress_fsm
// Packet framing controller: tracks header/payload/parity position, keeps the
// running parity, and owns the registered error flag.
//   clock       : clock, all state on posedge
//   resetn      : synchronous active-low reset
//   accept_i    : a source byte is taken this cycle (valid and not busy)
//   dataIn_i    : the source byte
//   load_o      : the accepted byte goes into the output slot
//   loadDest_o  : destination the loaded byte belongs to
//   inCheck_o   : FSM is in the one-cycle CHECK state
//   error_o     : packet error flag
// -----------------------------------------------------------------------------
module router_ingress_fsm
   import router_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int NUM_DEST = NUM_DEST_DEFAULT
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              accept_i,
   input  logic [DATA_W-1:0] dataIn_i,
   output logic              load_o,
   output logic [ADDR_W-1:0] loadDest_o,
   output logic              inCheck_o,
   output logic              error_o
);

   stateT             state_q,     state_d;
   logic [ADDR_W-1:0] dest_q,      dest_d;
   logic [LEN_W-1:0]  remCnt_q,    remCnt_d;
   logic [LEN_W:0]    dropCnt_q,   dropCnt_d;
   logic [DATA_W-1:0] parityAcc_q, parityAcc_d;
   logic              mismatch_q,  mismatch_d;
   logic              error_q,     error_d;

   logic [ADDR_W-1:0] hdrAddr;
   logic [LEN_W-1:0]  hdrLen;
   logic              hdrAddrValid;

   // Header fields are decoded straight off the incoming byte; they only
   // matter when the byte is accepted in IDLE.
   assign hdrAddr      = headerAddr(dataIn_i[7:0]);
   assign hdrLen       = headerLen(dataIn_i[7:0]);
   assign hdrAddrValid = (32'(hdrAddr) < NUM_DEST);

   // State register and per-packet bookkeeping. Reset drops any packet in
   // flight, so counters and the parity accumulator start clean.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         dest_q      <= '0;
         remCnt_q    <= '0;
         dropCnt_q   <= '0;
         parityAcc_q <= '0;
         mismatch_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         remCnt_q    <= remCnt_d;
         dropCnt_q   <= dropCnt_d;
         parityAcc_q <= parityAcc_d;
         mismatch_q  <= mismatch_d;
         error_q     <= error_d;
      end
   end

   // Next-state and slot-load decisions. A header with an out-of-range
   // address is swallowed together with its payload and parity byte (len+1
   // bytes) without touching the slot; error is raised once the last of
   // them has gone by. A valid header clears any earlier error because the
   // flag describes the most recent packet.
   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      remCnt_d    = remCnt_q;
      dropCnt_d   = dropCnt_q;
      parityAcc_d = parityAcc_q;
      mismatch_d  = mismatch_q;
      error_d     = error_q;
      load_o      = 1'b0;
      loadDest_o  = dest_q;

      unique case (state_q)
         IDLE: begin
            if (accept_i) begin
               if (hdrAddrValid) begin
                  dest_d      = hdrAddr;
                  remCnt_d    = hdrLen;
                  parityAcc_d = dataIn_i;
                  error_d     = 1'b0;
                  load_o      = 1'b1;
                  loadDest_o  = hdrAddr;
                  state_d     = (hdrLen != '0) ? PAYLOAD : PARITY;
               end else begin
                  dropCnt_d = {1'b0, hdrLen} + 1'b1;
                  state_d   = DROP;
               end
            end
         end

         PAYLOAD: begin
            if (accept_i) begin
               load_o      = 1'b1;
               parityAcc_d = parityAcc_q ^ dataIn_i;
               remCnt_d    = remCnt_q - 1'b1;
               if (remCnt_q == LEN_W'(1)) begin
                  state_d = PARITY;
               end
            end
         end

         PARITY: begin
            if (accept_i) begin
               load_o     = 1'b1;
               mismatch_d = (dataIn_i != parityAcc_q);
               state_d    = CHECK;
            end
         end

         CHECK: begin
            error_d = mismatch_q;
            state_d = IDLE;
         end

         DROP: begin
            if (accept_i) begin
               dropCnt_d = dropCnt_q - 1'b1;
               if (dropCnt_q == (LEN_W+1)'(1)) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign inCheck_o = (state_q == CHECK);
   assign error_o   = error_q;

endmodule

// File: rtl/router_ingress.sv
// -----------------------------------------------------------------------------
// router_ingress
// Input stage of the 1x3 router. Frames the incoming byte stream, checks
// parity, and steers each byte to a destination FIFO through a one-entry
// output slot, stalling the source while the slot cannot drain.
//   clock   : clock, all state on posedge
//   resetn  : synchronous active-low reset
//   bus     : router_ingress_if.slave (pkt_valid, data_in, fifo_full in;
//             busy, error, write_enb, dout out)
// -----------------------------------------------------------------------------
module router_ingress
   import router_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int NUM_DEST = NUM_DEST_DEFAULT
) (
   input  logic           clock,
   input  logic           resetn,
   router_ingress_if.slave bus
);

   logic                slotValid_q, slotValid_d;
   logic [DATA_W-1:0]   slotData_q,  slotData_d;
   logic [ADDR_W-1:0]   slotDest_q,  slotDest_d;

   logic [NUM_DEST-1:0] writeEnb;
   logic                slotStalled;
   logic                drain;
   logic                busy;
   logic                accept;
   logic                load;
   logic [ADDR_W-1:0]   loadDest;
   logic                inCheck;
   logic                fsmError;

   router_ingress_fsm #(
      .DATA_W   (DATA_W),
      .NUM_DEST (NUM_DEST)
   ) uFsm (
      .clock      (clock),
      .resetn     (resetn),
      .accept_i   (accept),
      .dataIn_i   (bus.data_in),
      .load_o     (load),
      .loadDest_o (loadDest),
      .inCheck_o  (inCheck),
      .error_o    (fsmError)
   );

   // The slot writes to its FIFO whenever that FIFO has room; when it does
   // not, the slot is stalled and the source must be held off so nothing is
   // overwritten. A full FIFO with an empty slot never stalls anything.
   always_comb begin
      writeEnb    = '0;
      slotStalled = 1'b0;
      for (int d = 0; d < NUM_DEST; d++) begin
         if (slotValid_q && (slotDest_q == ADDR_W'(d))) begin
            writeEnb[d] = ~bus.fifo_full[d];
            slotStalled = bus.fifo_full[d];
         end
      end
   end

   assign drain  = |writeEnb;
   assign busy   = slotStalled | inCheck;
   assign accept = bus.pkt_valid & ~busy;

   // Slot refill. Because busy covers the stalled case, a load only ever
   // happens into an empty slot or one that is draining on this same edge.
   always_comb begin
      slotValid_d = slotValid_q;
      slotData_d  = slotData_q;
      slotDest_d  = slotDest_q;
      if (load) begin
         slotValid_d = 1'b1;
         slotData_d  = bus.data_in;
         slotDest_d  = loadDest;
      end else if (drain) begin
         slotValid_d = 1'b0;
      end
   end

   // Slot register. Reset empties it and zeroes the data so dout reads 0.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         slotValid_q <= 1'b0;
         slotData_q  <= '0;
         slotDest_q  <= '0;
      end else begin
         slotValid_q <= slotValid_d;
         slotData_q  <= slotData_d;
         slotDest_q  <= slotDest_d;
      end
   end

   assign bus.busy      = busy;
   assign bus.error     = fsmError;
   assign bus.write_enb = writeEnb;
   assign bus.dout      = slotData_q;

endmodule

// File: tb/tb_router_ingress.sv
// -----------------------------------------------------------------------------
// tb_router_ingress
// Directed bench for router_ingress. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so every check sees the state left by
// the previous rising edge together with the inputs of the current cycle.
// -----------------------------------------------------------------------------
module tb_router_ingress;

   logic clock;
   logic resetn;
   int   errors;
   int   checks;

   router_ingress_if #(.DATA_W(8), .NUM_DEST(3)) bus ();

   router_ingress #(
      .DATA_W   (8),
      .NUM_DEST (3)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Present one cycle's worth of inputs just after the falling edge.
   task automatic applyStimulus(input logic rstn, input logic valid,
                                input logic [7:0] data, input logic [2:0] full);
      @(negedge clock);
      resetn        = rstn;
      bus.pkt_valid = valid;
      bus.data_in   = data;
      bus.fifo_full = full;
      #1;
   endtask

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Write strobe, busy and error for the current cycle.
   task automatic checkAll(input string tag, input logic [2:0] expWe,
                           input logic expBusy, input logic expErr);
      checkOutput({tag, ".we"},   32'(bus.write_enb), 32'(expWe));
      checkOutput({tag, ".busy"}, 32'(bus.busy),      32'(expBusy));
      checkOutput({tag, ".err"},  32'(bus.error),     32'(expErr));
   endtask

   // Whole directed sequence, one step per clock cycle.
   initial begin
      errors        = 0;
      checks        = 0;
      resetn        = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.data_in   = 8'h00;
      bus.fifo_full = 3'b000;

      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);

      // Reset state
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("rst", 3'b000, 1'b0, 1'b0);
      checkOutput("rst.dout", 32'(bus.dout), 32'h00);

      // Good packet to FIFO 1: 0D 11 22 33 parity 0D
      applyStimulus(1'b1, 1'b1, 8'h0D, 3'b000);
      checkAll("p1.hdr", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h11, 3'b000);
      checkAll("p1.b1", 3'b010, 1'b0, 1'b0);
      checkOutput("p1.b1.dout", 32'(bus.dout), 32'h0D);
      applyStimulus(1'b1, 1'b1, 8'h22, 3'b000);
      checkAll("p1.b2", 3'b010, 1'b0, 1'b0);
      checkOutput("p1.b2.dout", 32'(bus.dout), 32'h11);
      applyStimulus(1'b1, 1'b1, 8'h33, 3'b000);
      checkAll("p1.b3", 3'b010, 1'b0, 1'b0);
      checkOutput("p1.b3.dout", 32'(bus.dout), 32'h22);
      applyStimulus(1'b1, 1'b1, 8'h0D, 3'b000);
      checkAll("p1.par", 3'b010, 1'b0, 1'b0);
      checkOutput("p1.par.dout", 32'(bus.dout), 32'h33);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p1.chk", 3'b010, 1'b1, 1'b0);
      checkOutput("p1.chk.dout", 32'(bus.dout), 32'h0D);

      // Same packet with a bad parity byte, header straight after CHECK
      applyStimulus(1'b1, 1'b1, 8'h0D, 3'b000);
      checkAll("p2.hdr", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h11, 3'b000);
      checkAll("p2.b1", 3'b010, 1'b0, 1'b0);
      checkOutput("p2.b1.dout", 32'(bus.dout), 32'h0D);
      applyStimulus(1'b1, 1'b1, 8'h22, 3'b000);
      checkOutput("p2.b2.dout", 32'(bus.dout), 32'h11);
      applyStimulus(1'b1, 1'b1, 8'h33, 3'b000);
      checkOutput("p2.b3.dout", 32'(bus.dout), 32'h22);
      applyStimulus(1'b1, 1'b1, 8'hFF, 3'b000);
      checkAll("p2.par", 3'b010, 1'b0, 1'b0);
      checkOutput("p2.par.dout", 32'(bus.dout), 32'h33);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p2.chk", 3'b010, 1'b1, 1'b0);
      checkOutput("p2.chk.dout", 32'(bus.dout), 32'hFF);

      // Error visible; next valid header (08: FIFO 0, len 2) clears it
      applyStimulus(1'b1, 1'b1, 8'h08, 3'b000);
      checkAll("p2.err", 3'b000, 1'b0, 1'b1);

      // FIFO 0 full for four cycles with the header parked in the slot
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 8'hA1, 3'b001);
         checkAll($sformatf("p3.full%0d", i), 3'b000, 1'b1, 1'b0);
         checkOutput($sformatf("p3.full%0d.dout", i), 32'(bus.dout), 32'h08);
      end
      applyStimulus(1'b1, 1'b1, 8'hA1, 3'b000);
      checkAll("p3.hdrw", 3'b001, 1'b0, 1'b0);
      checkOutput("p3.hdrw.dout", 32'(bus.dout), 32'h08);
      applyStimulus(1'b1, 1'b1, 8'hB2, 3'b000);
      checkAll("p3.b1", 3'b001, 1'b0, 1'b0);
      checkOutput("p3.b1.dout", 32'(bus.dout), 32'hA1);
      applyStimulus(1'b1, 1'b1, 8'h1B, 3'b000);
      checkAll("p3.b2", 3'b001, 1'b0, 1'b0);
      checkOutput("p3.b2.dout", 32'(bus.dout), 32'hB2);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p3.chk", 3'b001, 1'b1, 1'b0);
      checkOutput("p3.chk.dout", 32'(bus.dout), 32'h1B);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b100);
      checkAll("p3.idle", 3'b000, 1'b0, 1'b0);

      // Invalid address 3, len 1: header + 2 bytes dropped, then error
      applyStimulus(1'b1, 1'b1, 8'h07, 3'b000);
      checkAll("p4.hdr", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h55, 3'b000);
      checkAll("p4.b1", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h66, 3'b000);
      checkAll("p4.b2", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p4.err", 3'b000, 1'b0, 1'b1);

      // Zero-length packet to FIFO 2: header 02, parity 02
      applyStimulus(1'b1, 1'b1, 8'h02, 3'b000);
      checkAll("p5.hdr", 3'b000, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'h02, 3'b000);
      checkAll("p5.par", 3'b100, 1'b0, 1'b0);
      checkOutput("p5.par.dout", 32'(bus.dout), 32'h02);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p5.chk", 3'b100, 1'b1, 1'b0);
      checkOutput("p5.chk.dout", 32'(bus.dout), 32'h02);

      // Reset in the middle of a 3-byte packet to FIFO 0 (header 0C)
      applyStimulus(1'b1, 1'b1, 8'h0C, 3'b000);
      checkAll("p6.hdr", 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h01, 3'b000);
      checkAll("p6.b1", 3'b001, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h02, 3'b000);
      checkAll("p6.b2", 3'b001, 1'b0, 1'b0);
      checkOutput("p6.b2.dout", 32'(bus.dout), 32'h01);
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);
      checkOutput("p6.rst.dout", 32'(bus.dout), 32'h02);

      // Fresh header 01 (FIFO 1, len 0) must be treated as a header
      applyStimulus(1'b1, 1'b1, 8'h01, 3'b000);
      checkAll("p6.after", 3'b000, 1'b0, 1'b0);
      checkOutput("p6.after.dout", 32'(bus.dout), 32'h00);
      applyStimulus(1'b1, 1'b1, 8'h01, 3'b000);
      checkAll("p7.par", 3'b010, 1'b0, 1'b0);
      checkOutput("p7.par.dout", 32'(bus.dout), 32'h01);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p7.chk", 3'b010, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
      checkAll("p7.idle", 3'b000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
